// File: rtl/gun_hv_pkg.sv
// Shared types and helpers for the light-gun HV latch: FSM states, counter/HV
// widths and the {V[7:0], H[8:1]} packing used for both live and latched values.
package gun_hv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ARMED      = 2'd1,
        ST_LATCHED    = 2'd2,
        ST_WAIT_FRAME = 2'd3
    } hv_state_e;

    localparam int CNT_W = 9;
    localparam int HV_W  = 16;
    localparam logic [CNT_W-1:0] HCNT_MAX = 9'd511;

    function automatic logic [HV_W-1:0] hv_pack(input logic [CNT_W-1:0] v,
                                                input logic [CNT_W-1:0] h);
        hv_pack = {v[7:0], h[8:1]};
    endfunction

endpackage

// File: rtl/gun_sensor_sync.sv
// Synchronises the asynchronous gun sensor and produces a one-cycle rising-edge
// pulse on CE_PIX cycles; GUN_HV_DEBOUNCE_EN requires two consecutive high samples.
module gun_sensor_sync
    import gun_hv_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic ce_pix,
    input  logic sensor_async,
    output logic sensor_edge
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   synced_s;
    logic                   hist1_r;

    assign synced_s = sync_r[SYNC_STAGES-1];

    // Metastability chain on the raw sensor pin
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_r <= '0;
        end else begin
            sync_r[0] <= sensor_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

`ifdef GUN_HV_DEBOUNCE_EN
    logic hist2_r;

    // Two-deep history of the synchronised sensor, sampled on pixel enables
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hist1_r <= 1'b0;
            hist2_r <= 1'b0;
        end else if (ce_pix) begin
            hist1_r <= synced_s;
            hist2_r <= hist1_r;
        end
    end

    // Edge only once the sensor has been high for exactly two pixel samples
    assign sensor_edge = ce_pix & synced_s & hist1_r & ~hist2_r;
`else
    // Previous synchronised sensor value, sampled on pixel enables
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hist1_r <= 1'b0;
        end else if (ce_pix) begin
            hist1_r <= synced_s;
        end
    end

    assign sensor_edge = ce_pix & synced_s & ~hist1_r;
`endif

endmodule

// File: rtl/gun_hv_latch.sv
// Light-gun HV counter latch: beam position counters, capture FSM and interrupt.
// Optional sensor debounce is enabled with the GUN_HV_DEBOUNCE_EN macro.
module gun_hv_latch
    import gun_hv_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int VSAT        = 511
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            CE_PIX,
    input  logic            HDE,
    input  logic            VDE,
    input  logic            SENSOR,
    input  logic            LATCH_EN,
    input  logic            INT_EN,
    input  logic            INT_ACK,
    input  logic            HV_RD,
    output logic [HV_W-1:0] HV_OUT,
    output logic            INT_REQ,
    output logic            LATCHED
);

    localparam logic [CNT_W-1:0] VSAT_C = CNT_W'(VSAT);

    logic             sensor_edge_s;
    logic             hde_prev_r;
    logic             vde_prev_r;
    logic             hde_rise_s;
    logic             hde_fall_s;
    logic             vde_rise_s;
    logic [CNT_W-1:0] hcnt_r;
    logic [CNT_W-1:0] vcnt_r;
    hv_state_e        state_r;
    logic [HV_W-1:0]  hv_hold_r;
    logic [HV_W-1:0]  hv_out_r;
    logic             int_req_r;
    logic             latched_r;

    gun_sensor_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sensor_sync (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .ce_pix       (CE_PIX),
        .sensor_async (SENSOR),
        .sensor_edge  (sensor_edge_s)
    );

    assign hde_rise_s = CE_PIX &  HDE & ~hde_prev_r;
    assign hde_fall_s = CE_PIX & ~HDE &  hde_prev_r;
    assign vde_rise_s = CE_PIX &  VDE & ~vde_prev_r;

    // Beam position counters and the display-enable history they key off
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hde_prev_r <= 1'b0;
            vde_prev_r <= 1'b0;
            hcnt_r     <= '0;
            vcnt_r     <= '0;
        end else if (CE_PIX) begin
            hde_prev_r <= HDE;
            vde_prev_r <= VDE;
            if (hde_rise_s) begin
                hcnt_r <= '0;
            end else if (hcnt_r != HCNT_MAX) begin
                hcnt_r <= hcnt_r + 9'd1;
            end
            if (vde_rise_s) begin
                vcnt_r <= '0;
            end else if (hde_fall_s && (vcnt_r < VSAT_C)) begin
                vcnt_r <= vcnt_r + 9'd1;
            end
        end
    end

    // Capture FSM; first sensor edge per frame wins, dropping LATCH_EN aborts
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r   <= ST_IDLE;
            hv_hold_r <= '0;
            latched_r <= 1'b0;
        end else if (!LATCH_EN) begin
            state_r   <= ST_IDLE;
            latched_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r   <= ST_ARMED;
                    latched_r <= 1'b0;
                end
                ST_ARMED: begin
                    if (sensor_edge_s) begin
                        state_r   <= ST_LATCHED;
                        hv_hold_r <= hv_pack(vcnt_r, hcnt_r);
                        latched_r <= 1'b1;
                    end
                end
                ST_LATCHED: begin
                    if (HV_RD) begin
                        state_r <= ST_WAIT_FRAME;
                    end
                end
                ST_WAIT_FRAME: begin
                    if (vde_rise_s) begin
                        state_r   <= ST_ARMED;
                        latched_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    latched_r <= 1'b0;
                end
            endcase
        end
    end

    // HV read-back: frozen capture while latched, otherwise the live beam position
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hv_out_r <= '0;
        end else if (latched_r) begin
            hv_out_r <= hv_hold_r;
        end else begin
            hv_out_r <= hv_pack(vcnt_r, hcnt_r);
        end
    end

    // Interrupt request; a fresh sensor edge beats a simultaneous acknowledge
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            int_req_r <= 1'b0;
        end else if (sensor_edge_s && INT_EN) begin
            int_req_r <= 1'b1;
        end else if (INT_ACK || !INT_EN) begin
            int_req_r <= 1'b0;
        end
    end

    assign HV_OUT  = hv_out_r;
    assign INT_REQ = int_req_r;
    assign LATCHED = latched_r;

endmodule

// File: tb/tb_gun_hv_latch.sv
// Self-checking bench for gun_hv_latch: directed capture/interrupt/reset scenarios
// followed by randomized traffic, all checked against a behavioural model.
module tb_gun_hv_latch;

    localparam int SYNC = 2;
    localparam int VSAT = 511;
`ifdef GUN_HV_DEBOUNCE_EN
    localparam int DEB = 1;
`else
    localparam int DEB = 0;
`endif
    localparam int M_IDLE = 0, M_ARMED = 1, M_LATCHED = 2, M_WAIT = 3;

    logic        CLK = 1'b0;
    logic        RESET_N, CE_PIX, HDE, VDE, SENSOR, LATCH_EN, INT_EN, INT_ACK, HV_RD;
    logic [15:0] HV_OUT;
    logic        INT_REQ, LATCHED;

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model state
    int          m_h, m_v, m_st, m_run;
    bit          m_hde_p, m_vde_p, m_int, m_lat;
    bit [SYNC-1:0] m_sp;
    logic [15:0] m_hold, m_out;

    always #5 CLK = ~CLK;

    gun_hv_latch #(.SYNC_STAGES(SYNC), .VSAT(VSAT)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .CE_PIX(CE_PIX), .HDE(HDE), .VDE(VDE),
        .SENSOR(SENSOR), .LATCH_EN(LATCH_EN), .INT_EN(INT_EN), .INT_ACK(INT_ACK),
        .HV_RD(HV_RD), .HV_OUT(HV_OUT), .INT_REQ(INT_REQ), .LATCHED(LATCHED)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] hv_of(input int v, input int h);
        return 16'(((v % 256) * 256) + (h / 2));
    endfunction

    task automatic model_reset();
        m_h = 0; m_v = 0; m_st = M_IDLE; m_run = 0;
        m_hde_p = 1'b0; m_vde_p = 1'b0; m_int = 1'b0; m_lat = 1'b0;
        m_sp = '0; m_hold = 16'h0000; m_out = 16'h0000;
    endtask

    // One CLK of the reference model, using the inputs currently driven
    task automatic model_tick();
        bit synced, sedge, vrise;
        int nst;
        synced = m_sp[SYNC-1];
        sedge  = CE_PIX && synced && (m_run == DEB);
        vrise  = CE_PIX && VDE && !m_vde_p;
        m_out  = (m_st == M_LATCHED || m_st == M_WAIT) ? m_hold : hv_of(m_v, m_h);
        nst = m_st;
        if (!LATCH_EN) nst = M_IDLE;
        else begin
            case (m_st)
                M_IDLE:    nst = M_ARMED;
                M_ARMED:   if (sedge) begin nst = M_LATCHED; m_hold = hv_of(m_v, m_h); end
                M_LATCHED: if (HV_RD) nst = M_WAIT;
                M_WAIT:    if (vrise) nst = M_ARMED;
                default:   nst = M_IDLE;
            endcase
        end
        if (sedge && INT_EN) m_int = 1'b1;
        else if (INT_ACK || !INT_EN) m_int = 1'b0;
        if (CE_PIX) begin
            if (HDE && !m_hde_p) m_h = 0;
            else if (m_h < 511) m_h = m_h + 1;
            if (vrise) m_v = 0;
            else if (!HDE && m_hde_p && m_v < VSAT) m_v = m_v + 1;
            m_run = synced ? ((m_run < 3) ? m_run + 1 : 3) : 0;
            m_hde_p = HDE;
            m_vde_p = VDE;
        end
        m_sp  = {m_sp[SYNC-2:0], SENSOR};
        m_st  = nst;
        m_lat = (nst == M_LATCHED || nst == M_WAIT);
    endtask

    task automatic step(input bit ce, input bit hde, input bit vde, input bit sens);
        CE_PIX = ce; HDE = hde; VDE = vde; SENSOR = sens;
        model_tick();
        @(posedge CLK);
        #1;
        chk_eq("hv_out", HV_OUT, m_out);
        chk_eq("int_req", INT_REQ, m_int);
        chk_eq("latched", LATCHED, m_lat);
    endtask

    task automatic frame_start();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic run_line(input int hi, input int lo, input int p_at, input int p_len);
        for (int s = 0; s < hi; s++)
            step(1'b1, 1'b1, 1'b1, (s >= p_at) && (s < p_at + p_len));
        for (int s = 0; s < lo; s++) step(1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        bit seen;
        bit rh, rv, rs;
        RESET_N = 1'b0; CE_PIX = 1'b0; HDE = 1'b0; VDE = 1'b0; SENSOR = 1'b0;
        LATCH_EN = 1'b0; INT_EN = 1'b0; INT_ACK = 1'b0; HV_RD = 1'b0;
        model_reset();
        #12;
        chk_eq("rst_hv_out", HV_OUT, 16'h0000);
        chk_eq("rst_int_req", INT_REQ, 1'b0);
        chk_eq("rst_latched", LATCHED, 1'b0);
        #5;
        RESET_N = 1'b1;

        // Scenario 1: capture at line 100, pixel 200
        LATCH_EN = 1'b1;
        frame_start();
        for (int n = 0; n < 100; n++) run_line(2, 2, -1, 0);
        run_line(210, 4, 201 - SYNC - DEB, 6);
        chk_eq("s1_latched", LATCHED, 1'b1);
        chk_eq("s1_hv", HV_OUT, 16'h6464);
        for (int n = 101; n < 120; n++) run_line(2, 2, -1, 0);
        chk_eq("s1_hold", HV_OUT, 16'h6464);

        // Scenario 2: second pulse ignored, then next frame captures line 10 pixel 40
        run_line(80, 4, 50, 6);
        chk_eq("s2_ignored", HV_OUT, 16'h6464);
        HV_RD = 1'b1;
        step(1'b1, 1'b0, 1'b1, 1'b0);
        HV_RD = 1'b0;
        chk_eq("s2_rd_hold", HV_OUT, 16'h6464);
        chk_eq("s2_wait_latched", LATCHED, 1'b1);
        frame_start();
        chk_eq("s2_rearmed", LATCHED, 1'b0);
        for (int n = 0; n < 10; n++) run_line(2, 2, -1, 0);
        run_line(60, 4, 41 - SYNC - DEB, 6);
        chk_eq("s2_hv", HV_OUT, 16'h0A14);

        // Scenario 3: interrupt latency and ack colliding with a new edge
        INT_EN = 1'b1;
        for (int i = 0; i < SYNC + 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < SYNC + 2 + DEB && !seen; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1);
            seen = INT_REQ;
        end
        chk_eq("s3_int_latency", seen, 1'b1);
        for (int i = 0; i < SYNC + 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < SYNC + DEB; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        INT_ACK = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk_eq("s3_ack_vs_edge", INT_REQ, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        INT_ACK = 1'b0;
        chk_eq("s3_ack_clears", INT_REQ, 1'b0);

        // Scenario 5: asynchronous reset while interrupt pending and latched
        for (int i = 0; i < SYNC + 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < SYNC + DEB + 1; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        chk_eq("s5_pre_int", INT_REQ, 1'b1);
        chk_eq("s5_pre_latched", LATCHED, 1'b1);
        SENSOR = 1'b0;
        #2;
        RESET_N = 1'b0;
        #1;
        chk_eq("s5_async_int", INT_REQ, 1'b0);
        chk_eq("s5_async_latched", LATCHED, 1'b0);
        chk_eq("s5_async_hv", HV_OUT, 16'h0000);
        repeat (3) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk_eq("s5_no_residual_int", INT_REQ, 1'b0);

        // Scenario 4: dropping LATCH_EN while latched returns to live output
        INT_EN = 1'b0;
        for (int i = 0; i < SYNC + DEB + 1; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        chk_eq("s4_latched", LATCHED, 1'b1);
        LATCH_EN = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk_eq("s4_idle", LATCHED, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk_eq("s4_live", HV_OUT, hv_of(m_v, m_h - 1));

`ifdef GUN_HV_DEBOUNCE_EN
        // Scenario 6: one-pixel glitch rejected, three-pixel pulse captured
        LATCH_EN = 1'b1; INT_EN = 1'b1;
        for (int i = 0; i < SYNC + 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < SYNC + 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk_eq("s6_glitch_latch", LATCHED, 1'b0);
        chk_eq("s6_glitch_int", INT_REQ, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < SYNC + 2; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk_eq("s6_pulse_latch", LATCHED, 1'b1);
        chk_eq("s6_pulse_int", INT_REQ, 1'b1);
`endif

        // Randomized traffic against the model
        rh = 1'b0; rv = 1'b0; rs = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 15) == 0) rh = ~rh;
            if ($urandom_range(0, 99) == 0) rv = ~rv;
            if ($urandom_range(0, 7) == 0) rs = ~rs;
            if ($urandom_range(0, 39) == 0) LATCH_EN = ~LATCH_EN;
            if ($urandom_range(0, 59) == 0) INT_EN = ~INT_EN;
            INT_ACK = ($urandom_range(0, 9) == 0);
            HV_RD   = ($urandom_range(0, 9) == 0);
            step(1'($urandom_range(0, 1)), rh, rv, rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gun_hv_latch.md
GUN_HV_LATCH -- requirements
Module: gun_hv_latch

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of flip-flop stages that synchronise the SENSOR input.
REQ-002 Parameter VSAT, default 511: saturation value of the internal line counter.
REQ-003 CLK  in  1  system clock; every flop samples on the rising edge.
REQ-004 RESET_N  in  1  reset; asynchronous, active-low.
REQ-005 CE_PIX  in  1  pixel clock enable; the counters and the state machine advance only when it is high.
REQ-006 HDE, VDE  in  1 each  horizontal and vertical display enable from the video timing.
REQ-007 SENSOR  in  1  light-gun sensor output, asynchronous, active-high.
REQ-008 LATCH_EN  in  1  register bit that enables the HV latch.
REQ-009 INT_EN  in  1  register bit that enables the external interrupt.
REQ-010 INT_ACK  in  1  single-cycle interrupt acknowledge.
REQ-011 HV_RD  in  1  single-cycle CPU read strobe for the HV counter.
REQ-012 HV_OUT  out  16  HV value, {V[7:0], H[8:1]}.
REQ-013 INT_REQ  out  1  external interrupt request, level.
REQ-014 LATCHED  out  1  high while a latched value is being held.

Function
REQ-015 hcnt is 9 bits: on a CE_PIX cycle with an HDE rising edge it loads 0; on other CE_PIX cycles it increments, saturating at 511.
REQ-016 vcnt is 9 bits: on a CE_PIX cycle with a VDE rising edge it loads 0; on a CE_PIX cycle with an HDE falling edge it increments, saturating at VSAT.
REQ-017 Edge detection for HDE and VDE uses the previous value sampled on CE_PIX.
REQ-018 The sensor edge is a rising edge of the synchronised SENSOR, evaluated on CE_PIX cycles only.
REQ-019 States are IDLE, ARMED, LATCHED and WAIT_FRAME; the reset state is IDLE.
REQ-020 IDLE -> ARMED when LATCH_EN=1.
REQ-021 Any state -> IDLE when LATCH_EN=0, at the next CLK, and INT_REQ is not cleared by this.
REQ-022 ARMED -> LATCHED on a sensor edge; on that same cycle {vcnt[7:0], hcnt[8:1]} is captured into hv_hold.
REQ-023 LATCHED -> WAIT_FRAME on HV_RD; hv_hold is retained.
REQ-024 WAIT_FRAME -> ARMED on a CE_PIX cycle with a VDE rising edge.
REQ-025 Sensor edges that arrive in LATCHED or WAIT_FRAME are ignored; the first capture per frame wins.
REQ-026 HV_OUT equals hv_hold in LATCHED and WAIT_FRAME, and the live counter value in IDLE and ARMED; it is registered and updates one CLK after the state or counter change.
REQ-027 LATCHED is high exactly in the LATCHED and WAIT_FRAME states.
REQ-028 INT_REQ is set on a sensor edge when INT_EN=1, in any state including IDLE, and is independent of LATCH_EN.
REQ-029 INT_REQ is cleared by INT_ACK or by INT_EN=0.
REQ-030 If INT_ACK and a new sensor edge occur on the same cycle, the set wins and INT_REQ stays 1.
REQ-031 If HV_RD and a sensor edge occur on the same cycle in ARMED, the capture happens and HV_RD returns the pre-capture live value.
REQ-032 Latency from the SENSOR pin rising to LATCHED=1 is SYNC_STAGES CLKs plus up to one CE_PIX period, plus 1 CLK.

Reset
REQ-033 While RESET_N=0: state is IDLE; hcnt, vcnt, hv_hold and HV_OUT are 0; INT_REQ=0; LATCHED=0; synchroniser and edge-detect flops are 0.
REQ-034 Reset asserted mid-frame or mid-latch aborts the capture with no residual interrupt.
REQ-035 After reset release, the first VDE rising edge aligns vcnt.

Configuration
REQ-036 With GUN_HV_DEBOUNCE_EN defined, a sensor edge is qualified only after synchronised SENSOR has been 1 for 2 consecutive CE_PIX cycles, so a single-pixel glitch causes neither a capture nor an interrupt; latency grows by one CE_PIX.
REQ-037 Without GUN_HV_DEBOUNCE_EN, the raw synchronised rising edge is used.

Structure
REQ-038 A shared package gun_hv_pkg holds the state enum, HV width constants, and the HV packing function {V[7:0], H[8:1]}.
REQ-039 One sub-module, gun_sensor_sync, contains the synchroniser, the optional debounce and the edge detector; the top level holds the counters, the FSM and the interrupt logic.

Verification
REQ-040 Scenario 1: LATCH_EN=1, SENSOR rises at line 100, pixel 200 -> HV_OUT=0x6464, LATCHED=1; the live counters keep running while HV_OUT holds.
REQ-041 Scenario 2: a second SENSOR pulse at line 120 in the same frame -> HV_OUT stays 0x6464; after HV_RD and the next VDE rising edge, a pulse at line 10, pixel 40 -> HV_OUT=0x0A14.
REQ-042 Scenario 3: INT_EN=1, SENSOR edge -> INT_REQ=1 within SYNC_STAGES+2 CLKs; INT_ACK together with a new edge on the same cycle -> INT_REQ remains 1.
REQ-043 Scenario 4: LATCH_EN dropped while in LATCHED -> next CLK state is IDLE, LATCHED=0 and HV_OUT is live.
REQ-044 Scenario 5: RESET_N asserted while INT_REQ=1 and LATCHED=1 -> both outputs are 0 with no CLK edge; after release, no interrupt occurs without a new edge.
REQ-045 Scenario 6: GUN_HV_DEBOUNCE_EN defined, SENSOR pulse lasting 1 CE_PIX -> no capture; pulse lasting 3 CE_PIX -> capture.
